// File: rtl/rs_dec_pkg.sv
// Shared constants and FSM encoding for the RS(16,8) key-equation scheduler.
package rs_dec_pkg;
  localparam int SYM_BW  = 8;
  localparam int SYN_W   = SYM_BW * 8;
  localparam int LAM_W   = SYM_BW * 5;
  localparam int OMG_W   = SYM_BW * 4;
  localparam int TIMEOUT = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } kes_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int N_LANE = 4,
  parameter int ID_W   = 2
) (
  input  logic [N_LANE-1:0] req_i,
  input  logic [ID_W-1:0]   ptr_i,
  output logic [N_LANE-1:0] gnt_o,
  output logic [ID_W-1:0]   id_o
);
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    sum   = '0;
    idx   = '0;
    // Walk from the farthest lane back to the pointer so the nearest requester wins.
    for (int i = N_LANE - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_i} + (ID_W + 1)'(i);
      if (sum >= (ID_W + 1)'(N_LANE)) sum = sum - (ID_W + 1)'(N_LANE);
      idx = sum[ID_W-1:0];
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        id_o       = idx;
      end
    end
  end
endmodule

// File: rtl/kes_sched.sv
// Shares one Berlekamp-Massey engine between syndrome lanes; zero syndromes bypass
// the engine, results leave through a single-entry valid/ready register.
module kes_sched
  import rs_dec_pkg::*;
#(
  parameter int N_LANE = 4,
  parameter int ID_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_LANE-1:0]       req,
  input  logic [N_LANE*SYN_W-1:0] syn_in,
  output logic [N_LANE-1:0]       gnt,
  output logic                    kes_start,
  output logic [SYN_W-1:0]        kes_syndrome,
  input  logic [LAM_W-1:0]        kes_lamda,
  input  logic [OMG_W-1:0]        kes_omega,
  input  logic                    kes_done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ID_W-1:0]         out_lane,
  output logic [LAM_W-1:0]        out_lamda,
  output logic [OMG_W-1:0]        out_omega,
  output logic                    out_err_free,
  output logic                    out_timeout,
  output logic                    busy,
  output logic [1:0]              dbg_state
);
  localparam int CNT_W = $clog2(TIMEOUT);

  // Output handshake: a result is transferred on any edge where out_valid & out_ready.
  // The register only loads when it is empty or being drained the same edge.
  kes_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d, lane_q, lane_d;
  logic [SYN_W-1:0]  syn_q, syn_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ov_q, ov_d, oef_q, oef_d, oto_q, oto_d;
  logic [ID_W-1:0]   olane_q, olane_d;
  logic [LAM_W-1:0]  olam_q, olam_d;
  logic [OMG_W-1:0]  oomg_q, oomg_d;

  logic              slot_free, load, ld_ef, ld_to;
  logic [LAM_W-1:0]  ld_lam;
  logic [OMG_W-1:0]  ld_omg;
  logic [N_LANE-1:0] arb_gnt;
  logic [ID_W-1:0]   arb_id;
  logic [SYN_W-1:0]  slice;

  rr_arbiter #(.N_LANE(N_LANE), .ID_W(ID_W)) u_arb (
    .req_i (req),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .id_o  (arb_id)
  );

  always_comb begin
    slice = '0;
    for (int i = 0; i < N_LANE; i++) begin
      if (arb_id == ID_W'(i)) slice = syn_in[i*SYN_W +: SYN_W];
    end
  end

  assign slot_free = !ov_q || out_ready;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    lane_d    = lane_q;
    syn_d     = syn_q;
    cnt_d     = cnt_q;
    gnt       = '0;
    kes_start = 1'b0;
    load      = 1'b0;
    ld_lam    = '0;
    ld_omg    = '0;
    ld_ef     = 1'b0;
    ld_to     = 1'b0;
    case (state_q)
      IDLE: begin
        if (slot_free && |req) begin
          gnt    = arb_gnt;
          syn_d  = slice;
          lane_d = arb_id;
          rr_d   = (arb_id == ID_W'(N_LANE - 1)) ? '0 : arb_id + 1'b1;
          if (slice == '0) begin
            load   = 1'b1;
            ld_lam = LAM_W'(1);
            ld_ef  = 1'b1;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        kes_start = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // A blocked output slot freezes the timeout count as well.
        if (slot_free) begin
          if (kes_done) begin
            load    = 1'b1;
            ld_lam  = kes_lamda;
            ld_omg  = kes_omega;
            state_d = IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            load    = 1'b1;
            ld_to   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ov_d    = ov_q;
    olane_d = olane_q;
    olam_d  = olam_q;
    oomg_d  = oomg_q;
    oef_d   = oef_q;
    oto_d   = oto_q;
    if (load) begin
      ov_d    = 1'b1;
      olane_d = lane_d;
      olam_d  = ld_lam;
      oomg_d  = ld_omg;
      oef_d   = ld_ef;
      oto_d   = ld_to;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      lane_q  <= '0;
      syn_q   <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      olane_q <= '0;
      olam_q  <= '0;
      oomg_q  <= '0;
      oef_q   <= 1'b0;
      oto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lane_q  <= lane_d;
      syn_q   <= syn_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      olane_q <= olane_d;
      olam_q  <= olam_d;
      oomg_q  <= oomg_d;
      oef_q   <= oef_d;
      oto_q   <= oto_d;
    end
  end

  assign kes_syndrome = syn_q;
  assign out_valid    = ov_q;
  assign out_lane     = olane_q;
  assign out_lamda    = olam_q;
  assign out_omega    = oomg_q;
  assign out_err_free = oef_q;
  assign out_timeout  = oto_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;
endmodule
